// File: rtl/req_ack_pkg.sv
// Shared types for the 4-phase req/ack transmit sequencer.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } req_ack_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer into the clk_tx domain; also usable as-is on the RX side.
module sync_2ff (
  input  logic clk_tx,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk_tx or negedge rst_b) begin
    if (!rst_b) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/req_ack_4ph_tx_arb.sv
// Round-robin arbiter that serialises N valid/ready producers onto one 4-phase req/ack channel,
// holding each word and its source index stable for the whole handshake.
module req_ack_4ph_tx_arb
  import req_ack_pkg::*;
#(
  parameter  int DW = 8,
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic            clk_tx,
  input  logic            rst_b,
  input  logic [N-1:0]    val,
  input  logic [N*DW-1:0] din,
  output logic [N-1:0]    rdy,
  output logic            req,
  input  logic            ack,
  output logic [DW-1:0]   dout,
  output logic [IW-1:0]   dout_id,
  output logic            busy
);

  localparam int unsigned NU = N;

  req_ack_state_e state_q;
  req_ack_state_e state_d;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  grant;
  logic           found;
  logic           accept;
  logic           ack_s;

  // Modulo-N increment that also works when N is not a power of two.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    return IW'(s % NU);
  endfunction

  sync_2ff u_ack_sync (
    .clk_tx (clk_tx),
    .rst_b  (rst_b),
    .d      (ack),
    .q      (ack_s)
  );

  // First valid requester at or after ptr; idle requesters cost no cycles.
  always_comb begin
    grant = ptr;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && val[wrap_add(ptr, k)]) begin
        grant = wrap_add(ptr, k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    rdy = '0;
    if (state_q == IDLE && found) rdy[grant] = 1'b1;
  end

  assign accept = |(val & rdy);
  assign busy   = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (ack_s)  state_d = REL;
      REL:     if (!ack_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_tx or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      req     <= 1'b0;
      ptr     <= '0;
      dout    <= '0;
      dout_id <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req     <= 1'b1;
        dout    <= din[grant*DW +: DW];
        dout_id <= grant;
        ptr     <= wrap_add(grant, 1);
      end else if (state_q == REQ && ack_s) begin
        req     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_req_ack_4ph_tx_arb.sv
// Bench for req_ack_4ph_tx_arb: round-robin model, loopback timing and a slow unrelated-clock receiver.
module tb_req_ack_4ph_tx_arb;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk_tx = 1'b0;
  logic            clk_rx = 1'b0;
  logic            rst_b;
  logic [N-1:0]    val;
  logic [N*DW-1:0] din;
  logic [N-1:0]    rdy;
  logic            req;
  logic            ack;
  logic [DW-1:0]   dout;
  logic [IW-1:0]   dout_id;
  logic            busy;

  int   total = 0;
  int   bad   = 0;
  int   m_ptr = 0;
  int   ack_mode;   // 0: ack_rnd, 1: loopback, 2: slow receiver
  logic ack_rnd;
  logic ack_drv;

  always #5 clk_tx = ~clk_tx;
  always #7 clk_rx = ~clk_rx;

  assign ack = (ack_mode == 1) ? req : (ack_mode == 2) ? ack_drv : ack_rnd;

  req_ack_4ph_tx_arb #(.DW(DW), .N(N)) dut (
    .clk_tx  (clk_tx),
    .rst_b   (rst_b),
    .val     (val),
    .din     (din),
    .rdy     (rdy),
    .req     (req),
    .ack     (ack),
    .dout    (dout),
    .dout_id (dout_id),
    .busy    (busy)
  );

  // Slow receiver on its own clock: answers each req edge after 10-40 of its cycles.
  initial begin
    ack_drv = 1'b0;
    forever begin
      @(posedge clk_rx);
      if (ack_mode == 2) begin
        if (req && !ack_drv) begin
          repeat ($urandom_range(40, 10)) @(posedge clk_rx);
          ack_drv = 1'b1;
        end else if (!req && ack_drv) begin
          repeat ($urandom_range(40, 10)) @(posedge clk_rx);
          ack_drv = 1'b0;
        end
      end
    end
  end

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic fill_din();
    for (int i = 0; i < N; i++) din[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic wait_idle();
    int c = 0;
    do begin
      @(negedge clk_tx);
      c++;
    end while (busy !== 1'b0 && c < 300);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_timeout: busy=%b want 0", busy); end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    ack_mode = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_tx);
      val = N'($urandom);
      ack_rnd = 1'($urandom);
      fill_din();
    end
    @(negedge clk_tx);
    #1;
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", req); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++;
    if (dout !== '0) begin bad++; $display("FAIL rst_dout: got %h want 00", dout); end
    total++;
    if (dout_id !== '0) begin bad++; $display("FAIL rst_dout_id: got %0d want 0", dout_id); end
    @(negedge clk_tx);
    rst_b = 1'b1;
    ack_rnd = 1'b0;
    val = 4'b0010;
    #1;
    total++;
    if (rdy !== 4'b0010) begin bad++; $display("FAIL rst_rdy: got %b want 0010", rdy); end
    val = '0;
    m_ptr = 0;
  endtask

  task automatic test_single();
    int first = -1;
    int hi = 0;
    int lo = 0;
    bit stable = 1'b1;
    bit busy0 = 1'b0;
    ack_mode = 1;
    fill_din();
    din[2*DW +: DW] = 8'hA5;
    @(negedge clk_tx);
    val = 4'b0100;
    #1;
    total++;
    if (rdy !== 4'b0100) begin bad++; $display("FAIL single_rdy: got %b want 0100", rdy); end
    for (int k = 0; k < 12 && first < 0; k++) begin
      @(negedge clk_tx);
      if (k == 0) begin
        busy0 = busy;
        din[2*DW +: DW] = 8'h3C;
      end
      if (req === 1'b1) begin
        if (lo == 0) hi++;
      end else lo++;
      if (dout !== 8'hA5 || dout_id !== 2'd2) stable = 1'b0;
      #1;
      if (rdy !== '0) first = k;
    end
    total++;
    if (busy0 !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy0); end
    total++;
    if (hi != 3) begin bad++; $display("FAIL single_req_high: got %0d cycles want 3", hi); end
    total++;
    if (lo != 4) begin bad++; $display("FAIL single_req_low: got %0d cycles want 4", lo); end
    total++;
    if (first != 6) begin bad++; $display("FAIL single_next_accept: got edge %0d want 7", first + 1); end
    total++;
    if (!stable) begin bad++; $display("FAIL single_hold: dout/dout_id moved, want A5/2 held"); end
    @(negedge clk_tx);
    val = '0;
    total++;
    if (dout !== 8'h3C || dout_id !== 2'd2 || req !== 1'b1)
      begin bad++; $display("FAIL single_second: got %h/%0d req=%b want 3c/2 req=1", dout, dout_id, req); end
    m_ptr = (2 + 1) % N;
    wait_idle();
  endtask

  task automatic test_fairness();
    int got = 0;
    int cyc = 0;
    int exp_id = 0;
    int last_acc = -1;
    int prev_id = -1;
    bit pend = 1'b0;
    logic [DW-1:0] exp_w = '0;
    ack_mode = 1;
    fill_din();
    while (got < 12 && cyc < 300) begin
      @(negedge clk_tx);
      cyc++;
      if (pend) begin
        pend = 1'b0;
        got++;
        total++;
        if (dout !== exp_w || dout_id !== IW'(exp_id) || busy !== 1'b1)
          begin bad++; $display("FAIL fair_word: got %h/%0d busy=%b want %h/%0d busy=1", dout, dout_id, busy, exp_w, exp_id); end
        total++;
        if (int'(dout_id) == prev_id) begin bad++; $display("FAIL fair_repeat: got id %0d twice, want rotation", dout_id); end
        prev_id = int'(dout_id);
        din[exp_id*DW +: DW] = DW'($urandom);
      end
      val = '1;
      #1;
      if (rdy !== '0) begin
        exp_id = rr_pick(val, m_ptr);
        total++;
        if (rdy !== (N'(1) << exp_id)) begin bad++; $display("FAIL fair_grant: got %b want %b", rdy, N'(1) << exp_id); end
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc != 7) begin bad++; $display("FAIL fair_period: got %0d cycles want 7", cyc - last_acc); end
        end
        last_acc = cyc;
        exp_w = din[exp_id*DW +: DW];
        m_ptr = (exp_id + 1) % N;
        pend = 1'b1;
      end
    end
    total++;
    if (got < 12) begin bad++; $display("FAIL fair_count: got %0d accepts want 12", got); end
    val = '0;
    wait_idle();
  endtask

  task automatic test_sparse();
    int first = -1;
    int exp_id;
    ack_mode = 1;
    fill_din();
    @(negedge clk_tx);
    val = 4'b0001;
    #1;
    exp_id = rr_pick(val, m_ptr);
    total++;
    if (rdy !== (N'(1) << exp_id)) begin bad++; $display("FAIL sparse_setup: got %b want %b", rdy, N'(1) << exp_id); end
    m_ptr = (exp_id + 1) % N;
    @(negedge clk_tx);
    val = '0;
    wait_idle();
    @(negedge clk_tx);
    val = 4'b1001;
    #1;
    exp_id = rr_pick(val, m_ptr);
    total++;
    if (rdy !== (N'(1) << exp_id) || exp_id != 3)
      begin bad++; $display("FAIL sparse_first: got %b want 1000", rdy); end
    m_ptr = (exp_id + 1) % N;
    for (int k = 0; k < 12 && first < 0; k++) begin
      @(negedge clk_tx);
      if (k == 0) begin
        val = 4'b0001;
        total++;
        if (dout_id !== 2'd3 || dout !== din[3*DW +: DW])
          begin bad++; $display("FAIL sparse_id3: got %h/%0d want %h/3", dout, dout_id, din[3*DW +: DW]); end
      end
      #1;
      if (rdy !== '0) first = k;
    end
    exp_id = rr_pick(val, m_ptr);
    total++;
    if (first != 6 || rdy !== (N'(1) << exp_id))
      begin bad++; $display("FAIL sparse_second: got rdy=%b at edge %0d want 0001 at edge 7", rdy, first + 1); end
    m_ptr = (exp_id + 1) % N;
    @(negedge clk_tx);
    val = '0;
    total++;
    if (dout_id !== 2'd0) begin bad++; $display("FAIL sparse_id0: got %0d want 0", dout_id); end
    wait_idle();
  endtask

  task automatic test_slow_rx();
    int got = 0;
    int cyc = 0;
    int exp_id = 0;
    int acklow = 0;
    bit pend = 1'b0;
    bit out = 1'b0;
    bit ack_hi = 1'b0;
    bit stab = 1'b1;
    bit early = 1'b0;
    logic [DW-1:0] exp_w = '0;
    logic [DW-1:0] hs_w = '0;
    logic [IW-1:0] hs_id = '0;
    ack_mode = 2;
    val = '0;
    while (got < 6 && cyc < 4000) begin
      @(negedge clk_tx);
      cyc++;
      if (pend) begin
        pend = 1'b0;
        got++;
        total++;
        if (dout !== exp_w || dout_id !== IW'(exp_id))
          begin bad++; $display("FAIL slow_word: got %h/%0d want %h/%0d", dout, dout_id, exp_w, exp_id); end
        hs_w = exp_w;
        hs_id = IW'(exp_id);
        val[exp_id] = 1'b0;
        out = 1'b1;
        ack_hi = 1'b0;
        acklow = 0;
      end else if (got > 0 && (dout !== hs_w || dout_id !== hs_id)) stab = 1'b0;
      if (out) begin
        if (ack) ack_hi = 1'b1;
        else if (ack_hi) acklow++;
      end
      for (int i = 0; i < N; i++) begin
        if (!val[i] && $urandom_range(3, 0) == 0) begin
          din[i*DW +: DW] = DW'($urandom);
          val[i] = 1'b1;
        end
      end
      #1;
      if (rdy !== '0) begin
        if (out && (!ack_hi || ack || acklow < 3)) early = 1'b1;
        exp_id = rr_pick(val, m_ptr);
        total++;
        if (rdy !== (N'(1) << exp_id)) begin bad++; $display("FAIL slow_grant: got %b want %b", rdy, N'(1) << exp_id); end
        exp_w = din[exp_id*DW +: DW];
        m_ptr = (exp_id + 1) % N;
        pend = 1'b1;
        out = 1'b0;
      end
    end
    total++;
    if (!stab) begin bad++; $display("FAIL slow_hold: dout/dout_id changed outside accept, want %h/%0d", hs_w, hs_id); end
    total++;
    if (early) begin bad++; $display("FAIL slow_early: got accept before ack fall synced, want none"); end
    total++;
    if (got < 6) begin bad++; $display("FAIL slow_count: got %0d accepts want 6", got); end
    val = '0;
    wait_idle();
    ack_mode = 0;
    ack_rnd = 1'b0;
  endtask

  task automatic test_reset_mid();
    int exp_id;
    ack_mode = 0;
    ack_rnd = 1'b0;
    fill_din();
    @(negedge clk_tx);
    val = 4'b0001;
    #1;
    exp_id = rr_pick(val, m_ptr);
    total++;
    if (rdy !== (N'(1) << exp_id)) begin bad++; $display("FAIL mid_setup: got %b want %b", rdy, N'(1) << exp_id); end
    m_ptr = (exp_id + 1) % N;
    @(negedge clk_tx);
    val = '0;
    ack_rnd = 1'b1;
    total++;
    if (req !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mid_pre: got req=%b busy=%b want 1/1", req, busy); end
    @(negedge clk_tx);
    rst_b = 1'b0;
    #1;
    total++;
    if (req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_abort: got req=%b busy=%b want 0/0", req, busy); end
    total++;
    if (dout !== '0 || dout_id !== '0) begin bad++; $display("FAIL mid_data: got %h/%0d want 00/0", dout, dout_id); end
    @(negedge clk_tx);
    rst_b = 1'b1;
    ack_rnd = 1'b0;
    m_ptr = 0;
    val = 4'b1001;
    #1;
    exp_id = rr_pick(val, m_ptr);
    total++;
    if (rdy !== (N'(1) << exp_id)) begin bad++; $display("FAIL mid_restart: got %b want %b", rdy, N'(1) << exp_id); end
    @(negedge clk_tx);
    ack_mode = 1;
    val = '0;
    total++;
    if (dout !== din[exp_id*DW +: DW] || dout_id !== IW'(exp_id))
      begin bad++; $display("FAIL mid_word: got %h/%0d want %h/%0d", dout, dout_id, din[exp_id*DW +: DW], exp_id); end
    m_ptr = (exp_id + 1) % N;
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0;
    val = '0;
    din = '0;
    ack_mode = 0;
    ack_rnd = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_sparse();
    test_slow_rx();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_ack_4ph_tx_arb.md
# req_ack_4ph_tx_arb

Round-robin arbiter and sequencer that shares one 4-phase req/ack transmit channel among N local requesters in the `clk_tx` domain. Each requester offers a word over valid/ready. The block grants one requester at a time, latches its word and source index, and runs the full 4-phase handshake (req↑, ack↑, req↓, ack↓) against the asynchronous `ack` before it grants again. It sits between the TX-side producers and the clock-crossing boundary.

## Interface
- `DW`, 8, data width.
- `N`, 4, number of requesters; N ≥ 2.
- `IW`, localparam, `$clog2(N)`, width of the source index.
- `clk_tx`  in  1  TX clock.
- `rst_b`  in  1  reset; one clock, asynchronous assert, active-low.
- `val`  in  N  per-requester valid.
- `din`  in  N×DW  per-requester data, packed; slice i belongs to requester i.
- `rdy`  out  N  per-requester ready, one-hot or zero.
- `req`  out  1  4-phase request, registered.
- `ack`  in  1  4-phase acknowledge, asynchronous to `clk_tx`.
- `dout`  out  DW  data to receiver, registered.
- `dout_id`  out  IW  index of the requester that owns `dout`, registered.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- `ack` passes through a 2-flop synchronizer (`ack_s`, reset 0). The FSM uses only `ack_s`, never raw `ack`.
- FSM states:
  - IDLE to REQ on accept.
  - REQ to REL when `ack_s` = 1.
  - REL to IDLE when `ack_s` = 0.
- Grant logic:
  - Grant goes to the first i with `val[i]` = 1, searching from `ptr` upward and wrapping modulo N.
  - `rdy[i]` = (state == IDLE) & (i == grant) & `val[i]`.
  - `rdy` may depend combinationally on `val`. Requesters must not make `val` depend on `rdy`.
- Accept means `val[i] & rdy[i]`. On accept:
  - `dout` <= `din[i]`.
  - `dout_id` <= i.
  - `req` <= 1.
  - `ptr` <= (i+1) mod N, wrapping from N-1 to 0.
- In REQ, when `ack_s` = 1, `req` <= 0.
- `dout` and `dout_id` change only on accept. They are stable from req↑ through ack↓.
- Requesters with `val` low are skipped with no penalty cycle.
- If `val[grant]` drops before accept, nothing happens and the grant is recomputed the next cycle.
- If `ack_s` rises while in IDLE (protocol error), it is ignored. An accept still requires IDLE.
- Reset values, asynchronous:
  - state = IDLE.
  - `req` = 0, `busy` = 0, `ptr` = 0.
  - `dout` = 0, `dout_id` = 0.
  - sync flops = 0.
  - `rdy` follows the combinational rule.
- Reset mid-handshake abandons the transfer. The receiver side must be reset together with this block.

## Timing
- Accept at edge E0:
  - `req`, `dout` and `dout_id` are valid after E0.
  - `busy` goes high after E0.
- `ack` changes become visible on `ack_s` 2 edges later. The FSM reacts on the following edge.
- Loopback (`ack` = `req`):
  - `req` is high for 3 cycles, then low for 4 cycles.
  - The next accept is no earlier than E7, so the minimum period is 7 cycles per word.
- `rdy` is zero in REQ and REL. At most one requester is accepted per handshake.

## Structure
- Package `req_ack_pkg`:
  - FSM state enum `req_ack_state_e` {IDLE, REQ, REL}.
  - Any shared protocol constants.
- Sub-module `sync_2ff`: 1-bit, 2-flop synchronizer on `clk_tx`/`rst_b`, reset 0. The same cell is reusable on the RX side.
- Round-robin search and FSM stay in the top module.

## Test plan
1. **Reset defaults:** reset asserted with random `val`/`ack` → `req`=0, `busy`=0, `dout`=0, `dout_id`=0; after release with `val`=4'b0010 → `rdy`=4'b0010.
2. **Single transfer, loopback:** requester 2 offers `din`=8'hA5 → `dout`=8'hA5 and `dout_id`=2 after accept; `req` high 3 cycles; next `rdy` no earlier than 7 cycles after the first accept.
3. **Fairness:** all four `val` held high with loopback → `dout_id` sequence 0,1,2,3,0,… with no requester served twice in a row.
4. **Sparse requesters:** `val`=4'b1001, `ptr`=1 → grant 3 first, then 0; no idle cycles spent on requesters 1 and 2.
5. **Slow asynchronous receiver:** `ack` driven from an unrelated clock with 10–40 cycle random delays:
   - `dout`/`dout_id` are stable while `req` or `ack` is high.
   - No second accept occurs before ack↓ has been synchronized.
6. **Reset mid-handshake:** `rst_b` asserted while in REQ with `ack`=1 → `req`=0 and `busy`=0 immediately; after release the first accepted requester is the lowest-indexed active one (`ptr`=0).
